// File: rtl/v_hier_qvec_mon.sv
// v_hier_qvec_mon: watches the 4-bit qvec bus from the hierarchical sub-block.
// Each value change becomes a timestamped {ts, old, new} record in a small
// event FIFO, which is drained over a valid/ready port. A saturating change
// counter and a sticky overflow flag feed the debug/status path.

module v_hier_qvec_mon #(
    parameter int DEPTH = 4,   // event FIFO entries, power of two, >= 2
    parameter int TS_W  = 8,   // free-running timestamp width
    parameter int CNT_W = 8    // saturating change counter width
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        qvec,
    input  logic              clr,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [TS_W+7:0]   ev_data,
    output logic [CNT_W-1:0]  change_cnt,
    output logic              ovf
);

    localparam int AW = $clog2(DEPTH);   // FIFO index width
    localparam int PW = AW + 1;          // pointer width, extra bit marks the lap

    // One logged change; the new value sits in the low nibble of ev_data.
    typedef struct packed {
        logic [TS_W-1:0] ts;
        logic [3:0]      old_q;
        logic [3:0]      new_q;
    } rec_t;

    // ------------------------------------------------------------------
    // Capture pipeline
    // ------------------------------------------------------------------
    logic [3:0]      q_r;       // qvec sampled this edge
    logic [3:0]      q_p;       // previous sample
    logic [1:0]      arm_sr;    // arming shift register
    logic            armed;
    logic [TS_W-1:0] ts;        // free-running timestamp, wraps
    logic            change;

    // Sample qvec, keep the previous sample and advance the timestamp.
    // NOTE: every clocked assignment uses <= so all registers update from
    // the same pre-edge values; blocking here would make q_p see the new q_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r    <= '0;
            q_p    <= '0;
            arm_sr <= '0;
            ts     <= '0;
        end else begin
            q_r    <= qvec;
            q_p    <= q_r;
            arm_sr <= {arm_sr[0], 1'b1};
            ts     <= ts + TS_W'(1);
        end
    end

    // Arming needs two post-reset edges: only then do both q_r and q_p
    // hold real bus samples, so a bus held at a non-zero value cannot be
    // mistaken for a change away from the reset value of q_p.
    assign armed  = arm_sr[1];
    assign change = armed && (q_r != q_p);

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    rec_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    rec_t          new_rec;

    // Same lap and same index means empty; opposite lap and same index
    // means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign ev_valid = !empty;
    assign pop      = ev_valid && ev_ready;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    // the push; only a full FIFO with no pop drops the record.
    assign push = change && (!full || pop);
    assign drop = change && full && !pop;

    // Build the record from the timestamp before this edge.
    always_comb begin
        new_rec       = '0;
        new_rec.ts    = ts;
        new_rec.old_q = q_p;
        new_rec.new_q = q_r;
    end

    // Storage write; gated by reset so a reset edge never leaves a write behind.
    // NOTE: the array has no reset; the pointers alone define which entries
    // are live, and ev_data is forced to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[AW-1:0]] <= new_rec;
        end
    end

    // Pointer update; reset empties the FIFO in the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Head entry, held stable until accepted; zero while empty.
    always_comb begin
        ev_data = '0;
        if (!empty) begin
            ev_data = mem[rd_ptr[AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Status: saturating change counter and sticky overflow
    // ------------------------------------------------------------------

    // Count every detected change, dropped or not; clr wins over a same-cycle
    // increment or overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            change_cnt <= '0;
            ovf        <= 1'b0;
        end else if (clr) begin
            change_cnt <= '0;
            ovf        <= 1'b0;
        end else begin
            if (change && (change_cnt != {CNT_W{1'b1}})) begin
                change_cnt <= change_cnt + CNT_W'(1);
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_v_hier_qvec_mon.sv
// Scoreboard bench for v_hier_qvec_mon: stimulus pushes the expected records,
// a negedge monitor pops and compares every accepted FIFO entry.

module tb_v_hier_qvec_mon;

    localparam int DEPTH = 4;
    localparam int TS_W  = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       qvec;
    logic             clr;
    logic             ev_valid;
    logic             ev_ready;
    logic [TS_W+7:0]  ev_data;
    logic [CNT_W-1:0] change_cnt;
    logic             ovf;

    int tests  = 0;
    int fails  = 0;
    int edge_n = 0;   // edges since reset release; edge 1 is the first

    logic [15:0] exp_q [$];
    logic [15:0] mon_exp;
    logic [3:0]  old_v;

    always #5 clk = ~clk;

    v_hier_qvec_mon #(
        .DEPTH (DEPTH),
        .TS_W  (TS_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .qvec       (qvec),
        .clr        (clr),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_data    (ev_data),
        .change_cnt (change_cnt),
        .ovf        (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic void expect_rec(input logic [7:0] ts_v, input logic [3:0] o, input logic [3:0] n);
        exp_q.push_back({ts_v, o, n});
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ticks(2);
        rst    = 1'b0;
        edge_n = 0;
    endtask

    // Monitor: every handshake must match the oldest expected record.
    always @(negedge clk) begin
        if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_record: got %h, none expected (edge %0d)", ev_data, edge_n);
            end else begin
                mon_exp = exp_q.pop_front();
                check("record", ev_data, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; clr = 1'b0; ev_ready = 1'b1; qvec = 4'h0;

        // Reset state
        ticks(2);
        check("rst_valid", ev_valid, 0);
        check("rst_data", ev_data, 0);
        check("rst_cnt", change_cnt, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0; edge_n = 0;

        // Quiet bus at 0 and at 5: no events either way
        repeat (10) begin tick(); check("idle0_valid", ev_valid, 0); end
        check("idle0_cnt", change_cnt, 0);
        qvec = 4'h5;
        do_reset();
        repeat (10) begin tick(); check("idle5_valid", ev_valid, 0); end
        check("idle5_cnt", change_cnt, 0);

        // Single change 0->3 captured at edge 5, valid after edge 6 for one cycle
        qvec = 4'h0; ev_ready = 1'b1;
        do_reset();
        ticks(4);
        qvec = 4'h3; expect_rec(8'd5, 4'h0, 4'h3);
        tick(); check("single_valid_e5", ev_valid, 0);
        tick(); check("single_valid_e6", ev_valid, 1);
        tick(); check("single_valid_e7", ev_valid, 0);
        check("single_cnt", change_cnt, 1);

        // Six toggles with ev_ready=0: four kept, two dropped
        qvec = 4'h0; ev_ready = 1'b0;
        do_reset();
        ticks(4);
        for (int i = 0; i < 6; i++) begin
            old_v = qvec;
            qvec  = (i % 2 == 0) ? 4'hF : 4'h0;
            if (i < 4) expect_rec(8'(5 + i), old_v, qvec);
            tick();
        end
        tick();   // edge 11: sixth change detected
        check("ovf_cnt", change_cnt, 6);
        check("ovf_flag", ovf, 1);
        check("ovf_valid", ev_valid, 1);
        ev_ready = 1'b1;
        tick(); check("drain_valid_e12", ev_valid, 1);
        tick(); check("drain_valid_e13", ev_valid, 1);
        tick(); check("drain_valid_e14", ev_valid, 1);
        tick(); check("drain_valid_e15", ev_valid, 0);
        // clr together with a change: status cleared, record still logged
        qvec = 4'h5; expect_rec(8'd16, 4'h0, 4'h5);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_cnt", change_cnt, 0);
        check("clr_ovf", ovf, 0);
        check("clr_push_valid", ev_valid, 1);
        tick(); check("clr_drain_valid", ev_valid, 0);

        // Full FIFO with simultaneous pop and push: nothing dropped
        qvec = 4'h0; ev_ready = 1'b0;
        do_reset();
        ticks(4);
        for (int i = 0; i < 4; i++) begin
            old_v = qvec;
            qvec  = (i % 2 == 0) ? 4'hF : 4'h0;
            expect_rec(8'(5 + i), old_v, qvec);
            tick();
        end
        qvec = 4'hF; expect_rec(8'd9, 4'h0, 4'hF);
        tick();            // edge 9: fourth entry lands, FIFO full
        ev_ready = 1'b1;
        tick();            // edge 10: pop and push together
        check("fullpp_ovf", ovf, 0);
        check("fullpp_cnt", change_cnt, 5);
        check("fullpp_valid", ev_valid, 1);
        ticks(3); check("fullpp_valid_e13", ev_valid, 1);
        tick();   check("fullpp_valid_e14", ev_valid, 0);

        // Counter saturation with timestamp wrap, then clr at saturation
        qvec = 4'h0; ev_ready = 1'b1;
        do_reset();
        ticks(4);
        for (int i = 0; i < 258; i++) begin
            old_v = qvec;
            qvec  = ~qvec;
            expect_rec(8'(edge_n + 1), old_v, qvec);
            tick();
        end
        ticks(2);
        check("sat_cnt", change_cnt, 255);
        check("sat_ovf", ovf, 0);
        old_v = qvec;
        qvec  = ~qvec;
        expect_rec(8'(edge_n + 1), old_v, qvec);
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("sat_clr_cnt", change_cnt, 0);
        check("sat_clr_valid", ev_valid, 1);
        tick(); check("sat_clr_drain", ev_valid, 0);

        // Reset with three entries queued, then ts restarts
        qvec = 4'h0; ev_ready = 1'b0;
        do_reset();
        ticks(4);
        for (int i = 0; i < 3; i++) begin
            qvec = (i % 2 == 0) ? 4'hF : 4'h0;
            tick();
        end
        tick();
        check("pre_rst_cnt", change_cnt, 3);
        check("pre_rst_valid", ev_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", ev_valid, 0);
        check("mid_rst_data", ev_data, 0);
        check("mid_rst_cnt", change_cnt, 0);
        check("mid_rst_ovf", ovf, 0);
        rst = 1'b0; edge_n = 0; ev_ready = 1'b1;
        ticks(4);
        qvec = 4'h2; expect_rec(8'd5, 4'hF, 4'h2);
        ticks(3);
        check("post_rst_cnt", change_cnt, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
